// File: rtl/spi_pkg.sv
// Shared types for the SPI controller: engine states and the TX FIFO entry.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } spi_state_t;

  // One queued transfer: the byte to send and whether to keep its response.
  typedef struct packed {
    logic       ignore;
    logic [7:0] data;
  } tx_entry_t;

  localparam int TX_ENTRY_W = $bits(tx_entry_t);

endpackage

// File: rtl/spi_fifo.sv
// Synchronous single-clock FIFO with asynchronous reset. A push is accepted
// when not full, or when a pop happens in the same cycle (the pop frees the
// slot first). DEPTH must be a power of two so pointers wrap naturally.
module spi_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_controller.sv
// Memory-mapped SPI master (mode 0, MSB first) with a TX FIFO. Each queued
// byte is shifted out while the response is shifted in; the response lands
// in the RX holding register unless the entry asked for it to be ignored.
//
// Handshake: spi_wr is a one-cycle strobe; the entry is accepted on that
// edge if the FIFO has room (or frees a slot the same cycle) and silently
// dropped otherwise. spi_rd with spi_addr=0 consumes the RX byte on that
// edge; a status read (spi_addr=1) has no side effect.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_wr,
  input  logic       spi_rd,
  input  logic       spi_addr,
  input  logic [7:0] spi_din,
  input  logic       spi_ignore_response,
  output logic [7:0] spi_dout,
  output logic       spi_buffer_full,
  output logic       spi_buffer_empty,
  output logic       spi_data_avail,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  spi_state_t state;
  tx_entry_t  push_entry;
  tx_entry_t  head;
  logic       fifo_empty;
  logic       fifo_full;
  logic [7:0] tx_sh;
  logic [7:0] rx_sh;
  logic [2:0] bit_cnt;
  logic [7:0] div_cnt;
  logic       ign_q;
  logic [7:0] dout_q;
  logic       avail_q;
  logic       miso_s1;
  logic       miso_s2;

  assign push_entry = '{ignore: spi_ignore_response, data: spi_din};

  spi_fifo #(
    .WIDTH (TX_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (spi_wr),
    .pop   (state == LOAD),
    .din   (push_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign spi_dout         = dout_q;
  assign spi_data_avail   = avail_q;
  assign spi_buffer_full  = fifo_full;
  assign spi_buffer_empty = fifo_empty && (state == IDLE);

  // Two-flop synchroniser for the asynchronous miso line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miso_s1 <= 1'b0;
      miso_s2 <= 1'b0;
    end else begin
      miso_s1 <= miso;
      miso_s2 <= miso_s1;
    end
  end

  // Transfer engine: divider, bit counter, shift registers and RX holding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= 1'b1;
      tx_sh   <= '0;
      rx_sh   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      ign_q   <= 1'b0;
      dout_q  <= '0;
      avail_q <= 1'b0;
    end else begin
      // A data read consumes the byte; a DONE write below overrides this.
      if (spi_rd && !spi_addr) avail_q <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= 1'b0;
          if (!fifo_empty) begin
            state <= LOAD;
            cs_n  <= 1'b0;
          end
        end
        LOAD: begin
          tx_sh   <= head.data;
          mosi    <= head.data[7];
          ign_q   <= head.ignore;
          bit_cnt <= '0;
          div_cnt <= '0;
          sclk    <= 1'b0;
          state   <= SHIFT;
        end
        SHIFT: begin
          // Capture one clk after the internal rise so the synchroniser's
          // latency is absorbed while sclk is still high.
          if (sclk && div_cnt == '0) rx_sh <= {rx_sh[6:0], miso_s2};
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == 3'd7) begin
                state <= DONE;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                tx_sh   <= {tx_sh[6:0], 1'b0};
                mosi    <= tx_sh[6];
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        DONE: begin
          if (!ign_q) begin
            dout_q  <= rx_sh;
            avail_q <= 1'b1;
          end
          if (!fifo_empty) begin
            state <= LOAD;
          end else begin
            state <= IDLE;
            cs_n  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller with CLK_DIV=2, FIFO_DEPTH=8.
module tb_spi_controller;

  logic       clk;
  logic       rst;
  logic       spi_wr;
  logic       spi_rd;
  logic       spi_addr;
  logic [7:0] spi_din;
  logic       spi_ignore_response;
  logic [7:0] spi_dout;
  logic       spi_buffer_full;
  logic       spi_buffer_empty;
  logic       spi_data_avail;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       cs_n;

  logic       loop_en;
  logic       miso_val;
  int         n_checks;
  int         n_fail;
  int         run_cnt;
  int         last_run;

  assign miso = loop_en ? mosi : miso_val;

  spi_controller #(
    .CLK_DIV    (2),
    .FIFO_DEPTH (8)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .spi_wr              (spi_wr),
    .spi_rd              (spi_rd),
    .spi_addr            (spi_addr),
    .spi_din             (spi_din),
    .spi_ignore_response (spi_ignore_response),
    .spi_dout            (spi_dout),
    .spi_buffer_full     (spi_buffer_full),
    .spi_buffer_empty    (spi_buffer_empty),
    .spi_data_avail      (spi_data_avail),
    .sclk                (sclk),
    .mosi                (mosi),
    .miso                (miso),
    .cs_n                (cs_n)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Length of the most recent contiguous cs_n-low window, in clk cycles.
  initial begin
    run_cnt  = 0;
    last_run = 0;
  end
  always @(negedge clk) begin
    if (rst) begin
      run_cnt = 0;
    end else if (!cs_n) begin
      run_cnt = run_cnt + 1;
    end else if (run_cnt != 0) begin
      last_run = run_cnt;
      run_cnt  = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] d, input logic ign);
    @(negedge clk);
    spi_wr = 1'b1;
    spi_din = d;
    spi_ignore_response = ign;
    @(negedge clk);
    spi_wr = 1'b0;
  endtask

  task automatic wait_cs(input logic lvl, input string tag);
    int n;
    n = 0;
    while (cs_n !== lvl && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, {31'd0, cs_n}, {31'd0, lvl});
  endtask

  task automatic wait_sclk_falls(input int cnt, input string tag);
    int n;
    int falls;
    logic prev;
    n = 0;
    falls = 0;
    prev = sclk;
    while (falls < cnt && n < 1000) begin
      @(negedge clk);
      n++;
      if (prev && !sclk) falls++;
      prev = sclk;
    end
    check_eq(tag, falls, cnt);
  endtask

  // Records mosi during each sclk-high phase of one byte.
  task automatic capture_byte(output logic [7:0] b);
    int n;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      while (sclk !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      b = {b[6:0], mosi};
      n = 0;
      while (sclk !== 1'b0 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  initial begin
    logic [7:0] cap;
    int lows;
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    spi_wr = 1'b0;
    spi_rd = 1'b0;
    spi_addr = 1'b0;
    spi_din = '0;
    spi_ignore_response = 1'b0;
    loop_en = 1'b0;
    miso_val = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_cs_n", {31'd0, cs_n}, 1);
    check_eq("rst_sclk", {31'd0, sclk}, 0);
    check_eq("rst_mosi", {31'd0, mosi}, 0);
    check_eq("rst_dout", {24'd0, spi_dout}, 32'h00);
    check_eq("rst_avail", {31'd0, spi_data_avail}, 0);
    check_eq("rst_full", {31'd0, spi_buffer_full}, 0);
    check_eq("rst_empty", {31'd0, spi_buffer_empty}, 1);
    rst = 1'b0;
    @(negedge clk);

    // Ignored response: miso high, holding register untouched
    miso_val = 1'b1;
    write_byte(8'h3C, 1'b1);
    check_eq("ign_empty_busy", {31'd0, spi_buffer_empty}, 0);
    wait_cs(1'b0, "ign_cs_low");
    wait_cs(1'b1, "ign_cs_high");
    @(negedge clk);
    check_eq("ign_dout", {24'd0, spi_dout}, 32'h00);
    check_eq("ign_avail", {31'd0, spi_data_avail}, 0);
    check_eq("ign_empty", {31'd0, spi_buffer_empty}, 1);
    check_eq("ign_cs_window", last_run, 34);

    // Loopback 0xA5
    loop_en = 1'b1;
    write_byte(8'hA5, 1'b0);
    wait_cs(1'b0, "a5_cs_low");
    capture_byte(cap);
    check_eq("a5_mosi_bits", {24'd0, cap}, 32'hA5);
    wait_cs(1'b1, "a5_cs_high");
    @(negedge clk);
    check_eq("a5_cs_window", last_run, 34);
    check_eq("a5_dout", {24'd0, spi_dout}, 32'hA5);
    check_eq("a5_avail", {31'd0, spi_data_avail}, 1);
    check_eq("a5_empty", {31'd0, spi_buffer_empty}, 1);

    // Status read keeps data_avail, data read clears it
    spi_rd = 1'b1;
    spi_addr = 1'b1;
    @(negedge clk);
    spi_rd = 1'b0;
    check_eq("stat_rd_avail", {31'd0, spi_data_avail}, 1);
    spi_rd = 1'b1;
    spi_addr = 1'b0;
    @(negedge clk);
    spi_rd = 1'b0;
    check_eq("data_rd_avail", {31'd0, spi_data_avail}, 0);
    check_eq("data_rd_dout", {24'd0, spi_dout}, 32'hA5);

    // Data read in the DONE cycle: new byte wins
    write_byte(8'h5A, 1'b0);
    wait_sclk_falls(8, "done_rd_falls");
    spi_rd = 1'b1;
    spi_addr = 1'b0;
    @(negedge clk);
    spi_rd = 1'b0;
    check_eq("done_rd_avail", {31'd0, spi_data_avail}, 1);
    check_eq("done_rd_dout", {24'd0, spi_dout}, 32'h5A);
    wait_cs(1'b1, "done_rd_cs_high");

    // Fill the FIFO while the engine is shifting, then overflow by one
    write_byte(8'h11, 1'b0);
    wait_cs(1'b0, "fill_cs_low");
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      spi_wr = 1'b1;
      spi_din = 8'h21 + 8'(i);
      spi_ignore_response = 1'b0;
      @(negedge clk);
    end
    spi_wr = 1'b0;
    check_eq("fill_full", {31'd0, spi_buffer_full}, 1);
    check_eq("fill_empty", {31'd0, spi_buffer_empty}, 0);
    spi_wr = 1'b1;
    spi_din = 8'h99;
    @(negedge clk);
    spi_wr = 1'b0;
    check_eq("ovf_full", {31'd0, spi_buffer_full}, 1);
    @(negedge clk);
    check_eq("drain_not_full", {31'd0, spi_buffer_full}, 1);
    wait_cs(1'b1, "fill_cs_high");
    @(negedge clk);
    check_eq("fill_cs_window", last_run, 9 * 34);
    check_eq("fill_dout", {24'd0, spi_dout}, 32'h28);
    check_eq("fill_avail", {31'd0, spi_data_avail}, 1);
    check_eq("fill_end_empty", {31'd0, spi_buffer_empty}, 1);
    check_eq("fill_end_full", {31'd0, spi_buffer_full}, 0);

    // Reset in the middle of bit 4
    write_byte(8'hC3, 1'b0);
    wait_sclk_falls(4, "rst_mid_falls");
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_cs_n", {31'd0, cs_n}, 1);
    check_eq("mid_rst_sclk", {31'd0, sclk}, 0);
    check_eq("mid_rst_empty", {31'd0, spi_buffer_empty}, 1);
    check_eq("mid_rst_full", {31'd0, spi_buffer_full}, 0);
    check_eq("mid_rst_dout", {24'd0, spi_dout}, 32'h00);
    check_eq("mid_rst_avail", {31'd0, spi_data_avail}, 0);
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!cs_n) lows++;
    end
    check_eq("post_rst_idle", lows, 0);
    check_eq("post_rst_dout", {24'd0, spi_dout}, 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
